// File: rtl/pps_mem_access_pkg.sv
// Shared encodings for the PPS memory-access stage: FSM states, memop type codes
// and load-extension helpers.
package pps_mem_access_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   localparam logic [6:0] tMEM_OP_NULL   = 7'd0;
   localparam logic [6:0] tMEM_OP_WORD   = 7'd1;
   localparam logic [6:0] tMEM_OP_HWORD  = 7'd2;
   localparam logic [6:0] tMEM_OP_BYTE   = 7'd3;
   localparam logic [6:0] tMEM_OP_HWORDU = 7'd4;
   localparam logic [6:0] tMEM_OP_BYTEU  = 7'd5;

   function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
      return {{24{sgn & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
      return {{16{sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/pps_load_align.sv
// Load data alignment: picks the byte/halfword lane from the low address bits and
// sign- or zero-extends it. Purely combinational.
module pps_load_align
   import pps_mem_access_pkg::*;
#(
   parameter int TYPE_W = 7
) (
   input  logic [31:0]       data,
   input  logic [1:0]        addr,
   input  logic [TYPE_W-1:0] op_type,
   output logic [31:0]       result
);

   localparam logic [TYPE_W-1:0] T_NULL   = TYPE_W'(tMEM_OP_NULL);
   localparam logic [TYPE_W-1:0] T_WORD   = TYPE_W'(tMEM_OP_WORD);
   localparam logic [TYPE_W-1:0] T_HWORD  = TYPE_W'(tMEM_OP_HWORD);
   localparam logic [TYPE_W-1:0] T_BYTE   = TYPE_W'(tMEM_OP_BYTE);
   localparam logic [TYPE_W-1:0] T_HWORDU = TYPE_W'(tMEM_OP_HWORDU);
   localparam logic [TYPE_W-1:0] T_BYTEU  = TYPE_W'(tMEM_OP_BYTEU);

   logic [31:0] shifted;
   logic [7:0]  lane;
   logic [15:0] half;

   always_comb begin
      shifted = data >> {addr, 3'b000};
      lane    = shifted[7:0];
      half    = addr[1] ? data[31:16] : data[15:0];
      case (op_type)
         T_NULL,
         T_WORD:   result = data;
         T_HWORD:  result = ext16(half, 1'b1);
         T_HWORDU: result = ext16(half, 1'b0);
         T_BYTE:   result = ext8(lane, 1'b1);
         T_BYTEU:  result = ext8(lane, 1'b0);
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/pps_mem_access.sv
// PPS memory-access stage: runs a WAIT_STATES+1 cycle async-SRAM access per memop,
// stalling upstream while in ACCESS; non-memory ops pass to WB in one cycle.
module pps_mem_access
   import pps_mem_access_pkg::*;
#(
   parameter int WAIT_STATES      = 1,
   parameter int ADDR_W           = 18,
   parameter int MEM_OP_TYPE_SIZE = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 MEM_Addr_in,
   input  logic [31:0]                 MEM_STData_in,
   input  logic [3:0]                  MEM_bwe_in,
   input  logic                        MEM_memop_in,
   input  logic                        MEM_memwr_in,
   input  logic [MEM_OP_TYPE_SIZE-1:0] MEM_memop_type_in,
   input  logic [4:0]                  MEM_inst_rd_in,
   input  logic                        MEM_RegWrite_in,
   output logic                        MEM_stall_out,
   output logic [31:0]                 WB_Result_out,
   output logic [4:0]                  WB_inst_rd_out,
   output logic                        WB_RegWrite_out,
   output logic [ADDR_W-1:0]           sram_addr,
   output logic [31:0]                 sram_dq_out,
   output logic                        sram_dq_oe,
   input  logic [31:0]                 sram_dq_in,
   output logic                        sram_ce_n,
   output logic                        sram_oe_n,
   output logic                        sram_we_n,
   output logic [3:0]                  sram_be_n
);

   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [1:0]                  addr_lo_q;
   logic [3:0]                  bwe_q;
   logic                        memwr_q;
   logic [MEM_OP_TYPE_SIZE-1:0] type_q;
   logic [4:0]                  rd_q;
   logic                        regwrite_q;

   logic       ce_n_d, oe_n_d, we_n_d, dq_oe_d;
   logic [3:0] be_n_d;
   logic       accept, last;
   logic [31:0] load_data;

   assign accept        = (state_q == ST_IDLE) && MEM_memop_in;
   assign last          = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
   assign MEM_stall_out = (state_q == ST_ACCESS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // SRAM pins are computed one cycle ahead and registered, so the pads see
   // clean edges; defaults are the idle (deasserted) levels.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      dq_oe_d = 1'b0;
      be_n_d  = 4'b1111;
      case (state_q)
         ST_IDLE: begin
            if (MEM_memop_in) begin
               state_d = ST_ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               ce_n_d  = 1'b0;
               if (MEM_memwr_in) begin
                  dq_oe_d = 1'b1;
                  be_n_d  = ~MEM_bwe_in;
                  we_n_d  = 1'b0;
               end else begin
                  oe_n_d = 1'b0;
                  be_n_d = 4'b0000;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               ce_n_d = 1'b0;
               if (memwr_q) begin
                  dq_oe_d = 1'b1;
                  be_n_d  = ~bwe_q;
                  // the cycle entered with count 0 is the address/data hold cycle
                  we_n_d  = (cnt_q == 4'd1);
               end else begin
                  oe_n_d = 1'b0;
                  be_n_d = 4'b0000;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   pps_load_align #(
      .TYPE_W (MEM_OP_TYPE_SIZE)
   ) u_align (
      .data    (sram_dq_in),
      .addr    (addr_lo_q),
      .op_type (type_q),
      .result  (load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sram_ce_n       <= 1'b1;
         sram_oe_n       <= 1'b1;
         sram_we_n       <= 1'b1;
         sram_be_n       <= 4'b1111;
         sram_dq_oe      <= 1'b0;
         sram_addr       <= '0;
         sram_dq_out     <= '0;
         addr_lo_q       <= '0;
         bwe_q           <= '0;
         memwr_q         <= 1'b0;
         type_q          <= '0;
         rd_q            <= '0;
         regwrite_q      <= 1'b0;
         WB_Result_out   <= '0;
         WB_inst_rd_out  <= '0;
         WB_RegWrite_out <= 1'b0;
      end else begin
         sram_ce_n  <= ce_n_d;
         sram_oe_n  <= oe_n_d;
         sram_we_n  <= we_n_d;
         sram_be_n  <= be_n_d;
         sram_dq_oe <= dq_oe_d;
         if (accept) begin
            sram_addr       <= MEM_Addr_in[ADDR_W+1:2];
            sram_dq_out     <= MEM_STData_in;
            addr_lo_q       <= MEM_Addr_in[1:0];
            bwe_q           <= MEM_bwe_in;
            memwr_q         <= MEM_memwr_in;
            type_q          <= MEM_memop_type_in;
            rd_q            <= MEM_inst_rd_in;
            regwrite_q      <= MEM_RegWrite_in;
            WB_RegWrite_out <= 1'b0;
         end else if (state_q == ST_IDLE) begin
            WB_Result_out   <= MEM_Addr_in;
            WB_inst_rd_out  <= MEM_inst_rd_in;
            WB_RegWrite_out <= MEM_RegWrite_in;
         end else if (last && !memwr_q) begin
            WB_Result_out   <= load_data;
            WB_inst_rd_out  <= rd_q;
            WB_RegWrite_out <= regwrite_q;
         end else begin
            WB_RegWrite_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pps_mem_access.sv
// Directed bench for pps_mem_access: a W=1 instance for the main sequence and a
// W=0 instance for back-to-back loads.
module tb_pps_mem_access;
   import pps_mem_access_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // W=1 instance
   logic [31:0] addr_in = '0, st_in = '0, dq_in = '0;
   logic [3:0]  bwe_in = '0;
   logic        memop_in = 1'b0, memwr_in = 1'b0, rw_in = 1'b0;
   logic [6:0]  type_in = '0;
   logic [4:0]  rd_in = '0;
   logic        stall, rw_out, dq_oe, ce_n, oe_n, we_n;
   logic [31:0] result, dq_out;
   logic [4:0]  rd_out;
   logic [17:0] s_addr;
   logic [3:0]  be_n;

   // W=0 instance
   logic [31:0] addr0 = '0, dq0 = '0;
   logic        memop0 = 1'b0;
   logic [4:0]  rd0 = '0;
   logic        stall0, rw0, dq_oe0, ce_n0, oe_n0, we_n0;
   logic [31:0] result0, dq_out0;
   logic [4:0]  rd_out0;
   logic [17:0] s_addr0;
   logic [3:0]  be_n0;

   int n_cmp = 0;
   int n_err = 0;

   pps_mem_access #(.WAIT_STATES(1), .ADDR_W(18), .MEM_OP_TYPE_SIZE(7)) u_dut (
      .clk(clk), .rst(rst),
      .MEM_Addr_in(addr_in), .MEM_STData_in(st_in), .MEM_bwe_in(bwe_in),
      .MEM_memop_in(memop_in), .MEM_memwr_in(memwr_in), .MEM_memop_type_in(type_in),
      .MEM_inst_rd_in(rd_in), .MEM_RegWrite_in(rw_in),
      .MEM_stall_out(stall), .WB_Result_out(result), .WB_inst_rd_out(rd_out),
      .WB_RegWrite_out(rw_out), .sram_addr(s_addr), .sram_dq_out(dq_out),
      .sram_dq_oe(dq_oe), .sram_dq_in(dq_in), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_be_n(be_n)
   );

   pps_mem_access #(.WAIT_STATES(0), .ADDR_W(18), .MEM_OP_TYPE_SIZE(7)) u_dut0 (
      .clk(clk), .rst(rst),
      .MEM_Addr_in(addr0), .MEM_STData_in(32'h0), .MEM_bwe_in(4'h0),
      .MEM_memop_in(memop0), .MEM_memwr_in(1'b0), .MEM_memop_type_in(tMEM_OP_WORD),
      .MEM_inst_rd_in(rd0), .MEM_RegWrite_in(1'b1),
      .MEM_stall_out(stall0), .WB_Result_out(result0), .WB_inst_rd_out(rd_out0),
      .WB_RegWrite_out(rw0), .sram_addr(s_addr0), .sram_dq_out(dq_out0),
      .sram_dq_oe(dq_oe0), .sram_dq_in(dq0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0),
      .sram_we_n(we_n0), .sram_be_n(be_n0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one memop for the accepting edge, then scrambles the inputs,
   // which must be ignored while stalled.
   task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [3:0] bwe,
                        input logic wr, input logic [6:0] ty, input logic [4:0] rd);
      addr_in = a; st_in = sd; bwe_in = bwe; memwr_in = wr; type_in = ty;
      rd_in = rd; rw_in = 1'b1; memop_in = 1'b1;
      step();
      memop_in = 1'b0; addr_in = 32'hFFFF_FFFF; st_in = 32'h5555_5555;
      bwe_in = 4'hF; memwr_in = ~wr; type_in = tMEM_OP_WORD; rd_in = 5'd31;
   endtask

   task automatic do_load(input string tag, input logic [31:0] a, input logic [6:0] ty,
                          input logic [31:0] data, input logic [31:0] exp);
      dq_in = data;
      issue(a, 32'h0, 4'h0, 1'b0, ty, 5'd6);
      step();
      step();
      chk(tag, result, exp);
   endtask

   initial begin
      step();
      step();
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rw", {31'b0, rw_out}, 32'd0);
      chk("rst_ctrl", {28'b0, ce_n, oe_n, we_n, dq_oe}, 32'b1110);
      chk("rst_be_n", {28'b0, be_n}, 32'hF);
      chk("rst_sram_addr", {14'b0, s_addr}, 32'd0);

      // non-memory pass-through
      rst = 1'b0;
      addr_in = 32'h0000_1234; rd_in = 5'd5; rw_in = 1'b1;
      step();
      chk("alu_result", result, 32'h0000_1234);
      chk("alu_rd", {27'b0, rd_out}, 32'd5);
      chk("alu_rw", {31'b0, rw_out}, 32'd1);
      chk("alu_stall", {31'b0, stall}, 32'd0);

      // lw at 0x100
      dq_in = 32'hDEAD_BEEF;
      issue(32'h100, 32'h0, 4'h0, 1'b0, tMEM_OP_WORD, 5'd7);
      chk("lw_stall1", {31'b0, stall}, 32'd1);
      chk("lw_addr", {14'b0, s_addr}, 32'h40);
      chk("lw_ctrl1", {28'b0, ce_n, oe_n, we_n, dq_oe}, 32'b0010);
      chk("lw_be_n", {28'b0, be_n}, 32'h0);
      chk("lw_bubble", {31'b0, rw_out}, 32'd0);
      step();
      chk("lw_stall2", {31'b0, stall}, 32'd1);
      chk("lw_ctrl2", {28'b0, ce_n, oe_n, we_n, dq_oe}, 32'b0010);
      step();
      chk("lw_stall_done", {31'b0, stall}, 32'd0);
      chk("lw_result", result, 32'hDEAD_BEEF);
      chk("lw_rd", {27'b0, rd_out}, 32'd7);
      chk("lw_rw", {31'b0, rw_out}, 32'd1);
      chk("lw_idle_ctrl", {28'b0, ce_n, oe_n, we_n, dq_oe}, 32'b1110);

      // alignment / extension
      do_load("lb_103",  32'h103, tMEM_OP_BYTE,   32'h80FF_0000, 32'hFFFF_FF80);
      do_load("lbu_103", 32'h103, tMEM_OP_BYTEU,  32'h80FF_0000, 32'h0000_0080);
      do_load("lb_102",  32'h102, tMEM_OP_BYTE,   32'h80FF_0000, 32'hFFFF_FFFF);
      do_load("lbu_101", 32'h101, tMEM_OP_BYTEU,  32'h1234_5678, 32'h0000_0056);
      do_load("lh_102",  32'h102, tMEM_OP_HWORD,  32'h80FF_0000, 32'hFFFF_80FF);
      do_load("lhu_102", 32'h102, tMEM_OP_HWORDU, 32'h80FF_0000, 32'h0000_80FF);
      do_load("lh_100",  32'h100, tMEM_OP_HWORD,  32'h1234_8001, 32'hFFFF_8001);
      do_load("lhu_101", 32'h101, tMEM_OP_HWORDU, 32'h1234_8001, 32'h0000_8001);
      do_load("null_op", 32'h102, tMEM_OP_NULL,   32'hCAFE_F00D, 32'hCAFE_F00D);
      do_load("bad_type", 32'h100, 7'h7F,         32'hCAFE_F00D, 32'h0000_0000);

      // sb at 0x101
      issue(32'h101, 32'h0000_AB00, 4'b0010, 1'b1, tMEM_OP_BYTE, 5'd8);
      chk("sb_stall1", {31'b0, stall}, 32'd1);
      chk("sb_be_n", {28'b0, be_n}, 32'b1101);
      chk("sb_we1", {29'b0, ce_n, we_n, dq_oe}, 32'b001);
      chk("sb_dq", dq_out, 32'h0000_AB00);
      chk("sb_addr", {14'b0, s_addr}, 32'h40);
      step();
      chk("sb_we_hold", {29'b0, ce_n, we_n, dq_oe}, 32'b011);
      chk("sb_be_n2", {28'b0, be_n}, 32'b1101);
      step();
      chk("sb_stall_done", {31'b0, stall}, 32'd0);
      chk("sb_rw", {31'b0, rw_out}, 32'd0);
      chk("sb_idle_ctrl", {29'b0, ce_n, we_n, dq_oe}, 32'b110);

      // reset during the first ACCESS cycle of a load
      dq_in = 32'hBAD0_BAD0;
      issue(32'h300, 32'h0, 4'h0, 1'b0, tMEM_OP_WORD, 5'd10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_stall", {31'b0, stall}, 32'd0);
      chk("abort_ce_n", {31'b0, ce_n}, 32'd1);
      chk("abort_rw", {31'b0, rw_out}, 32'd0);
      dq_in = 32'h1234_5678;
      issue(32'h200, 32'h0, 4'h0, 1'b0, tMEM_OP_WORD, 5'd9);
      chk("post_abort_addr", {14'b0, s_addr}, 32'h80);
      step();
      step();
      chk("post_abort_result", result, 32'h1234_5678);
      chk("post_abort_rd", {27'b0, rd_out}, 32'd9);
      chk("post_abort_rw", {31'b0, rw_out}, 32'd1);

      // W=0 back-to-back loads
      addr0 = 32'h10; rd0 = 5'd3; memop0 = 1'b1; dq0 = 32'h1111_1111;
      step();
      chk("b2b_stall1", {31'b0, stall0}, 32'd1);
      chk("b2b_addr1", {14'b0, s_addr0}, 32'h4);
      addr0 = 32'h14; rd0 = 5'd4;
      step();
      chk("b2b_stall1_done", {31'b0, stall0}, 32'd0);
      chk("b2b_result1", result0, 32'h1111_1111);
      chk("b2b_rd1", {27'b0, rd_out0}, 32'd3);
      chk("b2b_rw1", {31'b0, rw0}, 32'd1);
      step();
      chk("b2b_stall2", {31'b0, stall0}, 32'd1);
      chk("b2b_addr2", {14'b0, s_addr0}, 32'h5);
      chk("b2b_bubble2", {31'b0, rw0}, 32'd0);
      memop0 = 1'b0; dq0 = 32'h2222_2222;
      step();
      chk("b2b_stall2_done", {31'b0, stall0}, 32'd0);
      chk("b2b_result2", result0, 32'h2222_2222);
      chk("b2b_rd2", {27'b0, rd_out0}, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pps_mem_access.md
# pps_mem_access

Memory-access stage of the PPS pipeline, directly downstream of the execute stage. It takes the execute stage's memory request (address, aligned store data, byte enables, op type) and runs a multi-cycle access on the external asynchronous SRAM through a small FSM, stalling the pipeline while the access is in flight. It then aligns and sign- or zero-extends load data and registers the write-back bundle (result, destination register, write enable) for the WB stage.

## Interface
Parameters:
- WAIT_STATES, 1, extra SRAM cycles per access (0..15); each access occupies WAIT_STATES+1 ACCESS cycles.
- ADDR_W, 18, SRAM word-address width.
- MEM_OP_TYPE_SIZE, 7, width of the memop-type field.

Ports:
- clk  in  1  pipeline clock. One clock domain.
- rst  in  1  reset, synchronous, active-high.
- MEM_Addr_in  in  32  byte address (execute ALU result).
- MEM_STData_in  in  32  store data, already lane-aligned by execute.
- MEM_bwe_in  in  4  byte write enables, bit i = byte lane i (bits 8i+7:8i).
- MEM_memop_in  in  1  memory operation present.
- MEM_memwr_in  in  1  1 = store, 0 = load.
- MEM_memop_type_in  in  MEM_OP_TYPE_SIZE  op type.
- MEM_inst_rd_in  in  5  destination register.
- MEM_RegWrite_in  in  1  instruction writes rd.
- MEM_stall_out  out  1  upstream must hold; inputs are ignored while high.
- WB_Result_out  out  32  write-back value, registered.
- WB_inst_rd_out  out  5  registered.
- WB_RegWrite_out  out  1  registered.
- sram_addr  out  ADDR_W  word address, equal to MEM_Addr_in[ADDR_W+1:2] as latched.
- sram_dq_out  out  32  write data.
- sram_dq_oe  out  1  drive dq (pad tristate control).
- sram_dq_in  in  32  read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low controls.
- sram_be_n  out  4  active-low byte enables.

## Operation
- FSM states: IDLE, ACCESS.
- In IDLE, on a clock edge with MEM_memop_in=1, the block accepts the request:
  - It latches address, store data, bwe, memwr, type, rd and RegWrite.
  - It loads the wait counter with WAIT_STATES and enters ACCESS.
  - WB registers take a bubble (RegWrite=0).
- In IDLE with MEM_memop_in=0, it passes through: WB_Result_out←MEM_Addr_in (the ALU result), rd and RegWrite registered.
- In ACCESS, the counter decrements each cycle. The final cycle is the one where the counter equals 0. On that edge the FSM returns to IDLE and:
  - Load: the WB registers get the aligned data, the latched rd and the latched RegWrite.
  - Store: WB_RegWrite_out=0.
- SRAM pins during ACCESS:
  - sram_ce_n=0.
  - Load: oe_n=0, be_n=0000, dq_oe=0.
  - Store: dq_oe=1, be_n=~bwe, we_n=0 in every ACCESS cycle except the final one (the final cycle is address/data hold). With WAIT_STATES=0, we_n=0 for the single cycle.
- SRAM pins in IDLE: ce_n=oe_n=we_n=1, be_n=1111, dq_oe=0. All SRAM outputs are registered (no glitches).
- MEM_stall_out = (state==ACCESS), decoded directly from the state register.
- Load alignment (a = latched addr[1:0], lane k = bits 8k+7:8k):
  - WORD and NULL: raw data.
  - HWORD / HWORDU: halfword [31:16] if a[1]=1, else [15:0]; sign- / zero-extended.
  - BYTE / BYTEU: lane a; sign- / zero-extended.
  - Other type codes: the result is 0.
- Misaligned addresses raise no exception; unused low address bits are ignored.

## Timing
- Reset: state=IDLE, counter=0, MEM_stall_out=0, all WB outputs 0, SRAM controls deasserted as in IDLE, sram_addr=0, sram_dq_out=0.
- A non-memory instruction has 1-cycle latency.
- Load: accepted at edge E0; stall is high from after E0 until edge E(W+1); the result is visible after E(W+1). Total load-to-use latency is W+2 edges.
- Stall timing is identical for stores.
- Back-to-back memory operations: the second is accepted at the first IDLE edge after completion (no idle gap is required).
- Reset mid-ACCESS: abort. SRAM controls deassert at that edge, no WB write occurs, and the state returns to IDLE.
- Inputs that change while stall is high have no effect.

## Structure
- Add tMEM_OP_HWORDU and tMEM_OP_BYTEU to MIPS1000_defines.v, next to the existing tMEM_OP_NULL, WORD, HWORD and BYTE. Put the FSM state encodings there as well.
- Sub-module: pps_load_align, combinational, with inputs data, addr[1:0] and type and output result.

## Test plan
- Reset, then ALU op with Addr=0x0000_1234, rd=5, RegWrite=1 -> after one edge WB_Result_out=0x1234, rd=5, RegWrite=1, stall never high.
- W=1, lw at 0x100, SRAM model returns 0xDEADBEEF -> stall high for 2 cycles, sram_addr=0x40, oe_n=0; then WB_Result_out=0xDEADBEEF.
- lb at 0x103 with data 0x80FF_0000 -> 0xFFFF_FF80; lbu -> 0x0000_0080; lh at 0x102 -> 0xFFFF_80FF; lhu -> 0x0000_80FF.
- sb at 0x101, bwe=0010, data 0x0000_AB00 -> be_n=1101, we_n low for W cycles and high on the final cycle, dq_oe=1, WB_RegWrite_out=0.
- Assert rst in the first ACCESS cycle of a load -> next cycle: stall=0, ce_n=1, WB_RegWrite_out=0; a subsequent lw completes normally.
- Two consecutive lw with W=0 -> each stalls 1 cycle, and the results appear in order with the correct rd.
